// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command assembler.
// Optional trailing checksum byte is enabled with UART_CMD_CHECKSUM_EN.
package uart_cmd_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEFAULT_TIMEOUT = 52080;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  // Checksum byte that a sender must append after the payload.
  function automatic logic [BYTE_W-1:0] csum_expect(
    input logic [BYTE_W-1:0] sum
  );
    return ~sum;
  endfunction

endpackage

// File: rtl/uart_cmd_assembler_timer.sv
// Inter-byte timer: counts while enabled, cleared on demand,
// saturates at 16 bits, flags the last allowed cycle.
module inter_byte_timer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles NUM_BYTES UART bytes (MSB first) into one held command.
// Define UART_CMD_CHECKSUM_EN to require a trailing checksum byte.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int NUM_BYTES      = 3,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_rdy,
  input  logic [BYTE_W-1:0]         rx_data,
  output logic                      clr_rx_rdy,
  output logic [BYTE_W*NUM_BYTES-1:0] cmd,
  output logic                      cmd_rdy,
  input  logic                      clr_cmd_rdy,
  output logic                      frame_err,
  output logic                      chk_err
);

  localparam int CW = BYTE_W * NUM_BYTES;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_BYTES + 1;
`else
  localparam int FRAME_LEN = NUM_BYTES;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      byte_cnt_q;
  logic [2:0]      byte_cnt_d;
  logic [CW-1:0]   cmd_q;
  logic [CW-1:0]   cmd_d;
  logic [CW-1:0]   cmd_shift;
  logic            cmd_rdy_q;
  logic            cmd_rdy_d;
  logic            frame_err_q;
  logic            frame_err_d;
  logic            tmr_clr;
  logic            tmr_en;
  logic            tmr_expire;

`ifdef UART_CMD_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q;
  logic [BYTE_W-1:0] sum_d;
  logic              chk_err_q;
  logic              chk_err_d;
`endif

  assign cmd_shift = CW'({cmd_q, rx_data});

  inter_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    cmd_d       = cmd_q;
    frame_err_d = 1'b0;
    clr_rx_rdy  = 1'b0;
    tmr_clr     = 1'b1;
    tmr_en      = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    sum_d       = sum_q;
    chk_err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          cmd_d      = cmd_shift;
`ifdef UART_CMD_CHECKSUM_EN
          sum_d      = rx_data;
`endif
          if (FRAME_LEN == 1) begin
            state_d = HOLD;
          end else begin
            state_d    = COLLECT;
            byte_cnt_d = 3'd1;
          end
        end
      end
      COLLECT: begin
        tmr_en  = 1'b1;
        tmr_clr = 1'b0;
        // A byte in the expiry cycle wins over the timeout.
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          tmr_clr    = 1'b1;
          if (byte_cnt_q == LAST_IDX) begin
            byte_cnt_d = 3'd0;
`ifdef UART_CMD_CHECKSUM_EN
            if (rx_data == csum_expect(sum_q)) begin
              state_d = HOLD;
            end else begin
              state_d   = IDLE;
              chk_err_d = 1'b1;
            end
`else
            cmd_d   = cmd_shift;
            state_d = HOLD;
`endif
          end else begin
            cmd_d      = cmd_shift;
            byte_cnt_d = byte_cnt_q + 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
            sum_d      = sum_q + rx_data;
`endif
          end
        end else if (tmr_expire) begin
          frame_err_d = 1'b1;
          byte_cnt_d  = 3'd0;
          state_d     = IDLE;
        end
      end
      HOLD: begin
        if (clr_cmd_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_rdy_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= 3'd0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler (3-byte frames, short timeout).
// Honours UART_CMD_CHECKSUM_EN by appending checksum bytes.
module tb_uart_cmd_assembler;

  localparam int NB = 3;
  localparam int TO = 600;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int FL = NB + 1;
`else
  localparam int FL = NB;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frame_err;
  logic        chk_err;

  int n_tests = 0;
  int n_fail  = 0;
  int clr_cnt = 0;
  int fe_cnt  = 0;
  int ce_cnt  = 0;

  always #5 clk = ~clk;

  uart_cmd_assembler #(
    .NUM_BYTES     (NB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .frame_err  (frame_err),
    .chk_err    (chk_err)
  );

  always @(negedge clk) begin
    if (clr_rx_rdy) clr_cnt++;
    if (frame_err)  fe_cnt++;
    if (chk_err)    ce_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts and ends just after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got     = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (clr_rx_rdy) got = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_rdy = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte: no clr_rx_rdy for byte %h", b);
    end
  endtask

  task automatic gap(input int g);
    repeat (g) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] csum(input logic [23:0] p);
    logic [7:0] s;
    s = p[23:16] + p[15:8] + p[7:0];
    return ~s;
  endfunction

  task automatic send_tail(input logic [23:0] p);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(csum(p));
`else
    if (p[0] === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic send_frame(input logic [23:0] p, input int g2);
    send_byte(p[23:16]);
    send_byte(p[15:8]);
    gap(g2);
    send_byte(p[7:0]);
    send_tail(p);
  endtask

  task automatic release_cmd();
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    check("cmd_rdy_after_clr", 32'(cmd_rdy), 32'd0);
  endtask

  typedef struct {
    logic [23:0] payload;
    int          gap2;
    logic [23:0] exp_cmd;
  } vec_t;

  vec_t vecs[4];
  int   c0;
  int   f0;
  int   e0;

  initial begin
    vecs[0] = '{24'hA53C7E, 0,      24'hA53C7E};
    vecs[1] = '{24'h010203, 3,      24'h010203};
    vecs[2] = '{24'hFF0080, TO - 1, 24'hFF0080};
    vecs[3] = '{24'h000000, 1,      24'h000000};

    #2;
    check("rst_cmd",        32'(cmd),        32'd0);
    check("rst_cmd_rdy",    32'(cmd_rdy),    32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_chk_err",    32'(chk_err),    32'd0);
    check("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(2);

    for (int i = 0; i < 4; i++) begin
      c0 = clr_cnt;
      f0 = fe_cnt;
      send_frame(vecs[i].payload, vecs[i].gap2);
      check($sformatf("v%0d_cmd_rdy", i), 32'(cmd_rdy), 32'd1);
      check($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
      check($sformatf("v%0d_acks", i), 32'(clr_cnt - c0), 32'(FL));
      check($sformatf("v%0d_no_ferr", i), 32'(fe_cnt - f0), 32'd0);
      gap(3);
      check($sformatf("v%0d_held", i), 32'({cmd_rdy, cmd}),
            32'({1'b1, vecs[i].exp_cmd}));
      release_cmd();
      gap(1);
    end

    // Timeout drops a partial frame.
    f0 = fe_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    gap(TO);
    check("to_frame_err_pulse", 32'(frame_err), 32'd1);
    check("to_cmd_rdy", 32'(cmd_rdy), 32'd0);
    gap(1);
    check("to_frame_err_low", 32'(frame_err), 32'd0);
    check("to_ferr_count", 32'(fe_cnt - f0), 32'd1);
    send_frame(24'h010203, 0);
    check("to_next_cmd", 32'({cmd_rdy, cmd}), 32'({1'b1, 24'h010203}));
    release_cmd();
    gap(1);

    // Byte pending while HOLD waits for clr_cmd_rdy.
    send_frame(24'hA1B2C3, 0);
    rx_data = 8'h55;
    rx_rdy  = 1'b1;
    c0      = clr_cnt;
    gap(4);
    check("hold_no_ack", 32'(clr_cnt - c0), 32'd0);
    check("hold_frozen", 32'({cmd_rdy, cmd}), 32'({1'b1, 24'hA1B2C3}));
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    check("hold_clr_cycle_no_ack", 32'(clr_rx_rdy), 32'd0);
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    check("hold_release", 32'(cmd_rdy), 32'd0);
    @(negedge clk);
    check("idle_ack_pending", 32'(clr_rx_rdy), 32'd1);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    send_byte(8'h66);
    send_byte(8'h77);
    send_tail(24'h556677);
    check("pending_msb_cmd", 32'({cmd_rdy, cmd}), 32'({1'b1, 24'h556677}));
    release_cmd();
    gap(1);

    // Reset mid-frame.
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    check("midrst_cmd", 32'(cmd), 32'd0);
    check("midrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(24'h102030, 0);
    check("post_rst_cmd", 32'({cmd_rdy, cmd}), 32'({1'b1, 24'h102030}));

    // Reset mid-HOLD.
    rst_n = 1'b0;
    #1;
    check("holdrst", 32'({cmd_rdy, cmd}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(1);

`ifdef UART_CMD_CHECKSUM_EN
    e0 = ce_cnt;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'hF8);
    check("csum_bad_pulse", 32'(chk_err), 32'd1);
    check("csum_bad_no_rdy", 32'(cmd_rdy), 32'd0);
    gap(1);
    check("csum_bad_count", 32'(ce_cnt - e0), 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'hF9);
    check("csum_good", 32'({cmd_rdy, cmd}), 32'({1'b1, 24'h010203}));
    release_cmd();
`else
    e0 = 0;
    check("no_chk_err", 32'(ce_cnt - e0), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
